// File: rtl/mult4_seq_ctrl_if.sv
//------------------------------------------------------------------------------
// Module      : mult4_seq_ctrl_if
// Description : Start/operand request, shared-adder hookup and result bundle.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface mult4_seq_ctrl_if;
    logic       start;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] adder_x;
    logic [3:0] adder_y;
    logic       adder_cin;
    logic [3:0] adder_s;
    logic       adder_cout;
    logic       busy;
    logic       done;
    logic [7:0] product;

    // Environment side: switch/key logic plus the external adder.
    modport master (
        output start, a, b, adder_s, adder_cout,
        input  adder_x, adder_y, adder_cin, busy, done, product
    );

    // Controller side.
    modport slave (
        input  start, a, b, adder_s, adder_cout,
        output adder_x, adder_y, adder_cin, busy, done, product
    );
endinterface

`default_nettype wire

// File: rtl/mult4_seq_ctrl.sv
//------------------------------------------------------------------------------
// Module      : mult4_seq_ctrl
// Description : 4x4 unsigned shift-and-add multiplier sequencing one external
//               4-bit ripple adder over four steps.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mult4_seq_ctrl (
    input  wire logic         Clock,
    input  wire logic         Resetn,
    mult4_seq_ctrl_if.slave   bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] acc_q, acc_d;
    logic [3:0] mq_q, mq_d;
    logic [3:0] mcand_q, mcand_d;
    logic [1:0] cnt_q, cnt_d;
    logic [7:0] product_q, product_d;
    logic [4:0] step_sum;

    assign bus.adder_x   = acc_q;
    assign bus.adder_y   = ((state_q == S_RUN) && mq_q[0]) ? mcand_q : 4'b0000;
    assign bus.adder_cin = 1'b0;
    assign bus.busy      = (state_q == S_RUN);
    assign bus.done      = (state_q == S_DONE);
    assign bus.product   = product_q;

    assign step_sum = {bus.adder_cout, bus.adder_s};

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        mq_d      = mq_q;
        mcand_d   = mcand_q;
        cnt_d     = cnt_q;
        product_d = product_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    mcand_d = bus.a;
                    mq_d    = bus.b;
                    acc_d   = 4'd0;
                    cnt_d   = 2'd0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                // Carry lands in acc[3] via the shift, so no ninth bit is needed.
                {acc_d, mq_d} = {step_sum, mq_q[3:1]};
                cnt_d         = cnt_q + 2'd1;
                if (cnt_q == 2'd3) begin
                    product_d = {step_sum, mq_q[3:1]};
                    state_d   = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            state_q   <= S_IDLE;
            acc_q     <= 4'd0;
            mq_q      <= 4'd0;
            mcand_q   <= 4'd0;
            cnt_q     <= 2'd0;
            product_q <= 8'd0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            mq_q      <= mq_d;
            mcand_q   <= mcand_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mult4_seq_ctrl.sv
//------------------------------------------------------------------------------
// Module      : tb_mult4_seq_ctrl
// Description : Directed and exhaustive checks of mult4_seq_ctrl with a
//               behavioural ripple adder on the adder ports.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_mult4_seq_ctrl;

    logic Clock;
    logic Resetn;
    int   total;
    int   bad;

    mult4_seq_ctrl_if bus ();

    mult4_seq_ctrl dut (
        .Clock  (Clock),
        .Resetn (Resetn),
        .bus    (bus.slave)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    logic [3:0] rip_s;
    logic       rip_c;
    logic       rip_n;

    always_comb begin
        rip_s = 4'b0000;
        rip_c = bus.adder_cin;
        rip_n = 1'b0;
        for (int k = 0; k < 4; k++) begin
            rip_s[k] = bus.adder_x[k] ^ bus.adder_y[k] ^ rip_c;
            rip_n    = (bus.adder_x[k] & bus.adder_y[k]) |
                       (bus.adder_x[k] & rip_c) | (bus.adder_y[k] & rip_c);
            rip_c    = rip_n;
        end
    end

    assign bus.adder_s    = rip_s;
    assign bus.adder_cout = rip_c;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    // Full operation: accept, four RUN cycles, DONE, back to IDLE.
    task automatic do_op(input logic [3:0] av, input logic [3:0] bv,
                         input bit hold, input bit scramble);
        logic [7:0] expv;
        expv = {4'b0000, av} * {4'b0000, bv};
        bus.a     = av;
        bus.b     = bv;
        bus.start = 1'b1;
        check("idle_busy", {7'd0, bus.busy}, 8'd0);
        check("idle_done", {7'd0, bus.done}, 8'd0);
        step();
        if (!hold) bus.start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("run_busy", {7'd0, bus.busy}, 8'd1);
            check("run_done", {7'd0, bus.done}, 8'd0);
            check("run_adder_y", {4'd0, bus.adder_y}, bv[i] ? {4'd0, av} : 8'd0);
            check("run_cin", {7'd0, bus.adder_cin}, 8'd0);
            if (scramble) begin
                bus.a = 4'($urandom);
                bus.b = 4'($urandom);
            end
            step();
        end
        check("done_pulse", {7'd0, bus.done}, 8'd1);
        check("done_busy", {7'd0, bus.busy}, 8'd0);
        check("product", bus.product, expv);
        if (scramble) begin
            bus.a = 4'($urandom);
            bus.b = 4'($urandom);
        end
        step();
        check("after_done", {7'd0, bus.done}, 8'd0);
        check("product_hold", bus.product, expv);
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        Resetn     = 1'b0;
        bus.start  = 1'b0;
        bus.a      = 4'd0;
        bus.b      = 4'd0;
        step();
        step();
        Resetn = 1'b1;
        check("rst_busy", {7'd0, bus.busy}, 8'd0);
        check("rst_done", {7'd0, bus.done}, 8'd0);
        check("rst_product", bus.product, 8'd0);
        check("rst_adder_x", {4'd0, bus.adder_x}, 8'd0);
        check("rst_adder_y", {4'd0, bus.adder_y}, 8'd0);
        check("rst_cin", {7'd0, bus.adder_cin}, 8'd0);

        // Start low in IDLE must not launch anything.
        bus.a = 4'd7;
        bus.b = 4'd7;
        step();
        step();
        check("idle_noop_busy", {7'd0, bus.busy}, 8'd0);
        check("idle_noop_product", bus.product, 8'd0);

        do_op(4'hF, 4'hF, 1'b0, 1'b0);
        check("max_product", bus.product, 8'hE1);
        do_op(4'd13, 4'd11, 1'b0, 1'b0);
        check("p13x11", bus.product, 8'd143);
        do_op(4'd9, 4'd0, 1'b0, 1'b0);
        do_op(4'd0, 4'd7, 1'b0, 1'b0);

        // Back-to-back with operands churning during RUN.
        do_op(4'd3, 4'd5, 1'b1, 1'b1);
        do_op(4'd12, 4'd10, 1'b1, 1'b1);
        do_op(4'd15, 4'd1, 1'b1, 1'b1);
        do_op(4'd6, 4'd9, 1'b0, 1'b1);

        // Abort during the second RUN cycle.
        bus.a     = 4'd5;
        bus.b     = 4'd6;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        step();
        check("abort_pre_busy", {7'd0, bus.busy}, 8'd1);
        Resetn = 1'b0;
        step();
        Resetn = 1'b1;
        check("abort_busy", {7'd0, bus.busy}, 8'd0);
        check("abort_done", {7'd0, bus.done}, 8'd0);
        check("abort_product", bus.product, 8'd0);
        check("abort_adder_x", {4'd0, bus.adder_x}, 8'd0);
        for (int i = 0; i < 6; i++) begin
            step();
            check("abort_no_done", {7'd0, bus.done}, 8'd0);
            check("abort_idle", {7'd0, bus.busy}, 8'd0);
        end
        do_op(4'd5, 4'd6, 1'b0, 1'b0);
        check("p5x6", bus.product, 8'd30);

        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                do_op(4'(ia), 4'(ib), 1'b0, 1'b0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
